ssd_scan_driver: RTL and testbench

Parametrised multiplexed seven-segment scan driver. It is the successor to the fixed 8-digit hex/status display: digit count, scan rate and blink rate are set by parameters. It adds double-buffered frame loading, per-digit blink, decimal points, PWM brightness and a frame-done strobe. It sits between the lock/code-entry control logic, which supplies glyph codes, and the board anode/cathode pins.

---
 rtl/ssd_scan_driver.sv | 156 +++++++++++++++
 tb/tb_ssd_scan_driver.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_driver.sv
// Multiplexed seven-segment scan driver with double-buffered frames,
// per-digit blink, decimal points, PWM brightness and a frame-done strobe.
module ssd_scan_driver #(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_BITS = 17,
    parameter int BLINK_BITS   = 26
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [5*NUM_DIGITS-1:0] digit_data,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic [3:0]              brightness,
    input  logic                    load,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              cathode,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [4:0] GLYPH_BLANK = 5'h14;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    function automatic logic [6:0] seg_decode(input logic [4:0] code);
        logic [6:0] seg;
        case (code)
            5'h00:   seg = 7'b0000001;
            5'h01:   seg = 7'b1001111;
            5'h02:   seg = 7'b0010010;
            5'h03:   seg = 7'b0000110;
            5'h04:   seg = 7'b1001100;
            5'h05:   seg = 7'b0100100;
            5'h06:   seg = 7'b0100000;
            5'h07:   seg = 7'b0001111;
            5'h08:   seg = 7'b0000000;
            5'h09:   seg = 7'b0000100;
            5'h0A:   seg = 7'b0001000;
            5'h0B:   seg = 7'b1100000;
            5'h0C:   seg = 7'b0110001;
            5'h0D:   seg = 7'b1000010;
            5'h0E:   seg = 7'b0110000;
            5'h0F:   seg = 7'b0111000;
            5'h10:   seg = 7'b1111110;
            5'h11:   seg = 7'b1111001;
            5'h12:   seg = 7'b1000001;
            5'h13:   seg = 7'b1110001;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    logic [REFRESH_BITS-1:0] r_dwell_cnt;
    logic [IDX_W-1:0]        r_digit_idx;
    logic [BLINK_BITS-1:0]   r_blink_cnt;

    logic [4:0]              r_pend_glyph [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic [NUM_DIGITS-1:0]   r_pend_blink;
    logic [4:0]              r_act_glyph  [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   r_act_dp;
    logic [NUM_DIGITS-1:0]   r_act_blink;

    logic [NUM_DIGITS-1:0]   r_anode;
    logic [6:0]              r_cathode;
    logic                    r_dp;
    logic                    r_frame_done;

    logic [4:0]              w_in_glyph   [NUM_DIGITS];
    logic                    w_dwell_wrap;
    logic                    w_commit;
    logic [3:0]              w_level;
    logic                    w_blink_off;
    logic                    w_on;
    logic [NUM_DIGITS-1:0]   w_onehot_n;

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_in_glyph[i] = digit_data[5*i +: 5];
        end
    end

    // The commit is the last dwell clock of the last digit: the frame boundary.
    assign w_dwell_wrap = &r_dwell_cnt;
    assign w_commit     = w_dwell_wrap && (r_digit_idx == LAST_IDX);
    assign w_level      = r_dwell_cnt[REFRESH_BITS-1 -: 4];
    assign w_blink_off  = r_act_blink[r_digit_idx] & r_blink_cnt[BLINK_BITS-1];
    assign w_on         = (w_level <= brightness) && !w_blink_off;
    assign w_onehot_n   = ~(NUM_DIGITS'(1) << r_digit_idx);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_dwell_cnt <= '0;
            r_digit_idx <= '0;
            r_blink_cnt <= '0;
        end else begin
            r_dwell_cnt <= r_dwell_cnt + 1'b1;
            r_blink_cnt <= r_blink_cnt + 1'b1;
            if (w_dwell_wrap) begin
                r_digit_idx <= (r_digit_idx == LAST_IDX) ? '0 : r_digit_idx + 1'b1;
            end
        end
    end

    // A load coinciding with the commit goes straight into the active buffer.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_pend_glyph[i] <= GLYPH_BLANK;
                r_act_glyph[i]  <= GLYPH_BLANK;
            end
            r_pend_dp    <= '0;
            r_pend_blink <= '0;
            r_act_dp     <= '0;
            r_act_blink  <= '0;
        end else begin
            if (load) begin
                r_pend_glyph <= w_in_glyph;
                r_pend_dp    <= dp_mask;
                r_pend_blink <= blink_mask;
            end
            if (w_commit) begin
                r_act_glyph <= load ? w_in_glyph : r_pend_glyph;
                r_act_dp    <= load ? dp_mask    : r_pend_dp;
                r_act_blink <= load ? blink_mask : r_pend_blink;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_anode      <= '1;
            r_cathode    <= SEG_OFF;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_commit;
            if (w_on) begin
                r_anode   <= w_onehot_n;
                r_cathode <= seg_decode(r_act_glyph[r_digit_idx]);
                r_dp      <= ~r_act_dp[r_digit_idx];
            end else begin
                r_anode   <= '1;
                r_cathode <= SEG_OFF;
                r_dp      <= 1'b1;
            end
        end
    end

    assign anode      = r_anode;
    assign cathode    = r_cathode;
    assign dp         = r_dp;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver with 3 digits, 16-clock dwell, 64-clock blink period.
module tb_ssd_scan_driver;

    localparam int ND = 3;

    logic          clock;
    logic          reset;
    logic [5*ND-1:0] digit_data;
    logic [ND-1:0] dp_mask;
    logic [ND-1:0] blink_mask;
    logic [3:0]    brightness;
    logic          load;
    logic [ND-1:0] anode;
    logic [6:0]    cathode;
    logic          dp;
    logic          frame_done;

    int total = 0;
    int bad   = 0;
    int n     = 0;
    int cnt_a;
    int cnt_b;

    ssd_scan_driver #(
        .NUM_DIGITS  (ND),
        .REFRESH_BITS(4),
        .BLINK_BITS  (6)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .digit_data(digit_data),
        .dp_mask   (dp_mask),
        .blink_mask(blink_mask),
        .brightness(brightness),
        .load      (load),
        .anode     (anode),
        .cathode   (cathode),
        .dp        (dp),
        .frame_done(frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // n counts clock edges since reset release; outputs after edge n reflect scan state n-1.
    task automatic tick();
        @(posedge clock);
        #1;
        n++;
    endtask

    task automatic go_to(input int target);
        while (n < target) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic count_anode(input int last_n, input logic [ND-1:0] pat, output int cnt);
        cnt = 0;
        while (n < last_n) begin
            tick();
            if (anode === pat) cnt++;
        end
    endtask

    initial begin
        reset      = 1'b0;
        load       = 1'b0;
        brightness = 4'd15;
        digit_data = '0;
        dp_mask    = '0;
        blink_mask = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_anode", 32'(anode), 32'h7);
        chk("rst_cathode", 32'(cathode), 32'h7F);
        chk("rst_dp", 32'(dp), 32'h1);
        chk("rst_frame_done", 32'(frame_done), 32'h0);

        reset = 1'b1;
        n = 0;
        tick();
        chk("rel_anode", 32'(anode), 32'h6);
        chk("rel_cathode", 32'(cathode), 32'h7F);
        while (frame_done !== 1'b1 && n < 100) tick();
        chk("first_frame_done_n", 32'(n), 32'd48);

        // Load a frame; nothing changes until the wrap
        digit_data = {5'h12, 5'h0A, 5'h01};
        dp_mask    = 3'b010;
        load       = 1'b1;
        tick();
        load = 1'b0;
        chk("pre_commit_cathode", 32'(cathode), 32'h7F);
        go_to(96);
        chk("commit_frame_done", 32'(frame_done), 32'h1);
        chk("commit_old_anode", 32'(anode), 32'h3);
        chk("commit_old_cathode", 32'(cathode), 32'h7F);
        tick();
        chk("d0_anode", 32'(anode), 32'h6);
        chk("d0_cathode", 32'(cathode), 32'b1001111);
        chk("d0_dp", 32'(dp), 32'h1);
        go_to(113);
        chk("d1_anode", 32'(anode), 32'h5);
        chk("d1_cathode", 32'(cathode), 32'b0001000);
        chk("d1_dp", 32'(dp), 32'h0);
        go_to(128);
        chk("d1_hold_anode", 32'(anode), 32'h5);
        tick();
        chk("d2_anode", 32'(anode), 32'h3);
        chk("d2_cathode", 32'(cathode), 32'b1000001);
        chk("d2_dp", 32'(dp), 32'h1);
        go_to(143);
        chk("fd_low_143", 32'(frame_done), 32'h0);
        tick();
        chk("fd_high_144", 32'(frame_done), 32'h1);

        // Brightness PWM
        brightness = 4'd0;
        count_anode(160, 3'b110, cnt_a);
        chk("bright0_on_cycles", 32'(cnt_a), 32'd1);
        brightness = 4'd7;
        count_anode(176, 3'b101, cnt_a);
        chk("bright7_on_cycles", 32'(cnt_a), 32'd8);
        brightness = 4'd15;

        // Blink on digit 1
        blink_mask = 3'b010;
        load       = 1'b1;
        tick();
        load = 1'b0;
        go_to(208);
        count_anode(224, 3'b101, cnt_a);
        chk("blink_phase0_d1_on", 32'(cnt_a), 32'd16);
        go_to(288);
        count_anode(304, 3'b110, cnt_a);
        chk("blink_phase1_d0_on", 32'(cnt_a), 32'd16);
        count_anode(320, 3'b111, cnt_a);
        chk("blink_phase1_d1_off", 32'(cnt_a), 32'd16);
        go_to(368);
        count_anode(384, 3'b011, cnt_a);
        chk("blink_phase1_d2_on", 32'(cnt_a), 32'd16);

        // Overwritten pending load, then load exactly on the wrap
        go_to(400);
        digit_data = {5'h05, 5'h05, 5'h05};
        dp_mask    = 3'b000;
        blink_mask = 3'b000;
        load       = 1'b1;
        tick();
        load = 1'b0;
        go_to(410);
        digit_data = {5'h0C, 5'h0C, 5'h0C};
        load       = 1'b1;
        tick();
        load = 1'b0;
        go_to(432);
        cnt_a = 0;
        cnt_b = 0;
        while (n < 479) begin
            tick();
            if (cathode === 7'b0110001 && anode !== 3'b111) cnt_a++;
            if (cathode === 7'b0100100) cnt_b++;
        end
        chk("frame_C_cycles", 32'(cnt_a), 32'd47);
        chk("frame_5_cycles", 32'(cnt_b), 32'd0);
        digit_data = {5'h03, 5'h03, 5'h03};
        load       = 1'b1;
        tick();
        load = 1'b0;
        chk("wrap_frame_done", 32'(frame_done), 32'h1);
        chk("wrap_old_cathode", 32'(cathode), 32'b0110001);
        tick();
        chk("wrap_new_d0_anode", 32'(anode), 32'h6);
        chk("wrap_new_d0_cathode", 32'(cathode), 32'b0000110);
        go_to(497);
        chk("wrap_new_d1_anode", 32'(anode), 32'h5);
        chk("wrap_new_d1_cathode", 32'(cathode), 32'b0000110);
        chk("wrap_new_d1_dp", 32'(dp), 32'h1);

        // Mid-scan reset (digit 2, dwell 9) with a competing load
        go_to(521);
        reset      = 1'b0;
        digit_data = {5'h08, 5'h08, 5'h08};
        dp_mask    = 3'b111;
        load       = 1'b1;
        tick();
        reset = 1'b1;
        load  = 1'b0;
        chk("mid_rst_anode", 32'(anode), 32'h7);
        chk("mid_rst_cathode", 32'(cathode), 32'h7F);
        chk("mid_rst_dp", 32'(dp), 32'h1);
        chk("mid_rst_frame_done", 32'(frame_done), 32'h0);
        n = 0;
        tick();
        chk("restart_anode", 32'(anode), 32'h6);
        chk("restart_cathode", 32'(cathode), 32'h7F);
        chk("restart_dp", 32'(dp), 32'h1);
        go_to(17);
        chk("restart_d1_anode", 32'(anode), 32'h5);
        chk("restart_d1_cathode", 32'(cathode), 32'h7F);
        go_to(48);
        chk("restart_frame_done", 32'(frame_done), 32'h1);
        tick();
        chk("restart_next_anode", 32'(anode), 32'h6);
        chk("restart_next_cathode", 32'(cathode), 32'h7F);
        chk("restart_next_dp", 32'(dp), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
